// File: rtl/prbs_pkg.sv
// Shared types and helpers for the PRBS checker and its companion generators.
// prbs_parity takes zero-extended operands so one function serves any LFSR length up to 64.
package prbs_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int unsigned PARITY_MAX_W = 64;

  function automatic logic prbs_parity(
    input logic [PARITY_MAX_W-1:0] w,
    input logic [PARITY_MAX_W-1:0] taps
  );
    return ^(w & taps);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; a synchronous clear wins over an increment.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: hunts for the LFSR sequence, then flywheels on its own prediction.
//   state  | meaning
//   HUNT   | window loads from data_i; consecutive correct predictions build toward lock
//   LOCKED | window advances on its own prediction; mismatches are errors, loss evaluated per block
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned    N              = 8,
  parameter logic [N-1:0]   TAPS           = 8'b00000011,
  parameter int unsigned    LOCK_COUNT     = 16,
  parameter int unsigned    LOSS_WINDOW    = 64,
  parameter int unsigned    LOSS_THRESHOLD = 8,
  parameter int unsigned    CNT_W          = 32
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             valid_i,
  input  logic             data_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] bit_cnt_o
);

  localparam int unsigned FILL_W  = $clog2(N + 1);
  localparam int unsigned MATCH_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int unsigned BLK_W   = (LOSS_WINDOW > 1) ? $clog2(LOSS_WINDOW) : 1;
  localparam int unsigned LOSS_W  = $clog2(LOSS_THRESHOLD + 1);

  localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(N);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [BLK_W-1:0]   BLK_LAST   = BLK_W'(LOSS_WINDOW - 1);
  localparam logic [LOSS_W-1:0]  LOSS_LIMIT = LOSS_W'(LOSS_THRESHOLD);

  state_e              state_q, state_d;
  logic [N-1:0]        w_q, w_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic [BLK_W-1:0]    blk_q, blk_d;
  logic [LOSS_W-1:0]   loss_err_q, loss_err_d;
  logic                locked_q, locked_d;
  logic                err_q, err_d;

  logic                pred;
  logic                mismatch;
  logic [LOSS_W-1:0]   loss_next;
  logic                err_inc;
  logic                bit_inc;

  always_comb begin
    pred     = prbs_parity(PARITY_MAX_W'(w_q), PARITY_MAX_W'(TAPS));
    mismatch = (data_i != pred);
    bit_inc  = valid_i && (state_q == LOCKED);
    err_inc  = bit_inc && mismatch;
  end

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    fill_d     = fill_q;
    match_d    = match_q;
    blk_d      = blk_q;
    loss_err_d = loss_err_q;
    locked_d   = locked_q;
    err_d      = 1'b0;
    loss_next  = loss_err_q;

    if (valid_i) begin
      case (state_q)
        HUNT: begin
          w_d = {data_i, w_q[N-1:1]};
          if (fill_q != FILL_FULL) begin
            fill_d = fill_q + 1'b1;
          end else if (!mismatch && (w_q != '0)) begin
            // An all-zero window predicts zero forever, so it must never vouch for lock.
            if (match_q == MATCH_LAST) begin
              state_d    = LOCKED;
              locked_d   = 1'b1;
              match_d    = '0;
              blk_d      = '0;
              loss_err_d = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
          end
        end

        LOCKED: begin
          w_d       = {pred, w_q[N-1:1]};
          err_d     = mismatch;
          loss_next = loss_err_q + LOSS_W'(mismatch);
          if (loss_next == LOSS_LIMIT) begin
            // The window is kept; refill overwrites it with live data anyway.
            state_d    = HUNT;
            locked_d   = 1'b0;
            fill_d     = '0;
            match_d    = '0;
            blk_d      = '0;
            loss_err_d = '0;
          end else if (blk_q == BLK_LAST) begin
            blk_d      = '0;
            loss_err_d = '0;
          end else begin
            blk_d      = blk_q + 1'b1;
            loss_err_d = loss_next;
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= HUNT;
      w_q        <= '0;
      fill_q     <= '0;
      match_q    <= '0;
      blk_q      <= '0;
      loss_err_q <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      fill_q     <= fill_d;
      match_q    <= match_d;
      blk_q      <= blk_d;
      loss_err_q <= loss_err_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .inc      (err_inc),
    .clr      (clear_i),
    .q        (err_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_bit_cnt (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .inc      (bit_inc),
    .clr      (clear_i),
    .q        (bit_cnt_o)
  );

  assign locked_o = locked_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: feeds a default-parameter Fibonacci LFSR stream with planted errors.
module tb_prbs_checker;

  logic        clk_i    = 1'b0;
  logic        reset_ni = 1'b0;
  logic        valid_i  = 1'b0;
  logic        data_i   = 1'b0;
  logic        clear_i  = 1'b0;
  logic        locked_o;
  logic        err_o;
  logic [31:0] err_cnt_o;
  logic [31:0] bit_cnt_o;

  int tests = 0;
  int fails = 0;

  localparam logic [7:0] GEN_TAPS = 8'b00000011;
  logic [7:0] gen_state = 8'hA5;

  prbs_checker dut (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .valid_i   (valid_i),
    .data_i    (data_i),
    .clear_i   (clear_i),
    .locked_o  (locked_o),
    .err_o     (err_o),
    .err_cnt_o (err_cnt_o),
    .bit_cnt_o (bit_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Generator: output bit is the tap parity of its register, which then shifts the bit in at the top.
  task automatic next_gen(output logic b);
    b = ^(gen_state & GEN_TAPS);
    gen_state = {b, gen_state[7:1]};
  endtask

  task automatic step(input logic v, input logic d, input logic clr);
    valid_i = v;
    data_i  = d;
    clear_i = clr;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    clear_i = 1'b0;
  endtask

  task automatic send(input logic inv, input logic clr);
    logic b;
    next_gen(b);
    step(1'b1, b ^ inv, clr);
  endtask

  task automatic send_n(input int n);
    repeat (n) send(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    tests++; if (locked_o !== 1'b0) begin fails++; $display("FAIL reset_locked: got %0b want 0", locked_o); end
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err: got %0b want 0", err_o); end
    tests++; if (err_cnt_o !== 32'd0) begin fails++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt_o); end
    tests++; if (bit_cnt_o !== 32'd0) begin fails++; $display("FAIL reset_bit_cnt: got %0d want 0", bit_cnt_o); end
    reset_ni = 1'b1;
    repeat (3) step(1'b0, 1'b1, 1'b0);
    tests++; if (locked_o !== 1'b0) begin fails++; $display("FAIL idle_locked: got %0b want 0", locked_o); end
  endtask

  task automatic test_clean_lock();
    send_n(23);
    tests++; if (locked_o !== 1'b0) begin fails++; $display("FAIL lock_early: got %0b want 0 after 23 bits", locked_o); end
    send(1'b0, 1'b0);
    tests++; if (locked_o !== 1'b1) begin fails++; $display("FAIL lock_24: got %0b want 1 after 24 bits", locked_o); end
    send_n(1000);
    tests++; if (err_cnt_o !== 32'd0) begin fails++; $display("FAIL clean_err_cnt: got %0d want 0", err_cnt_o); end
    tests++; if (bit_cnt_o !== 32'd1000) begin fails++; $display("FAIL clean_bit_cnt: got %0d want 1000", bit_cnt_o); end
    tests++; if (locked_o !== 1'b1) begin fails++; $display("FAIL clean_locked: got %0b want 1", locked_o); end
  endtask

  task automatic test_single_error();
    int pulses;
    send_n(10);
    send(1'b1, 1'b0);
    tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL single_err_pulse: got %0b want 1", err_o); end
    tests++; if (err_cnt_o !== 32'd1) begin fails++; $display("FAIL single_err_cnt: got %0d want 1", err_cnt_o); end
    tests++; if (locked_o !== 1'b1) begin fails++; $display("FAIL single_locked: got %0b want 1", locked_o); end
    tests++; if (bit_cnt_o !== 32'd1011) begin fails++; $display("FAIL single_bit_cnt: got %0d want 1011", bit_cnt_o); end
    send(1'b0, 1'b0);
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL single_err_width: got %0b want 0", err_o); end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      send(1'b0, 1'b0);
      if (err_o !== 1'b0) pulses++;
    end
    tests++; if (pulses != 0) begin fails++; $display("FAIL flywheel_pulses: got %0d want 0", pulses); end
    tests++; if (err_cnt_o !== 32'd1) begin fails++; $display("FAIL flywheel_err_cnt: got %0d want 1", err_cnt_o); end
  endtask

  task automatic test_gaps_clear();
    int gap_pulses;
    gap_pulses = 0;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        if (err_o !== 1'b0) gap_pulses++;
      end
      send(1'b0, 1'b0);
      if (err_o !== 1'b0) gap_pulses++;
    end
    tests++; if (gap_pulses != 0) begin fails++; $display("FAIL gap_err_pulses: got %0d want 0", gap_pulses); end
    tests++; if (bit_cnt_o !== 32'd1062) begin fails++; $display("FAIL gap_bit_cnt: got %0d want 1062", bit_cnt_o); end
    tests++; if (err_cnt_o !== 32'd1) begin fails++; $display("FAIL gap_err_cnt: got %0d want 1", err_cnt_o); end
    send(1'b1, 1'b1);
    tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL clear_err_pulse: got %0b want 1", err_o); end
    tests++; if (err_cnt_o !== 32'd0) begin fails++; $display("FAIL clear_err_cnt: got %0d want 0", err_cnt_o); end
    tests++; if (bit_cnt_o !== 32'd0) begin fails++; $display("FAIL clear_bit_cnt: got %0d want 0", bit_cnt_o); end
    send(1'b0, 1'b0);
    tests++; if (bit_cnt_o !== 32'd1) begin fails++; $display("FAIL post_clear_bit_cnt: got %0d want 1", bit_cnt_o); end
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL post_clear_err: got %0b want 0", err_o); end
  endtask

  task automatic test_async_reset();
    #3;
    reset_ni = 1'b0;
    #1;
    tests++; if (locked_o !== 1'b0) begin fails++; $display("FAIL arst_locked: got %0b want 0", locked_o); end
    tests++; if (bit_cnt_o !== 32'd0) begin fails++; $display("FAIL arst_bit_cnt: got %0d want 0", bit_cnt_o); end
    #2;
    reset_ni = 1'b1;
    @(posedge clk_i);
    #1;
    send_n(23);
    tests++; if (locked_o !== 1'b0) begin fails++; $display("FAIL relock_early: got %0b want 0", locked_o); end
    send(1'b0, 1'b0);
    tests++; if (locked_o !== 1'b1) begin fails++; $display("FAIL relock_24: got %0b want 1", locked_o); end
    tests++; if (err_cnt_o !== 32'd0) begin fails++; $display("FAIL relock_err_cnt: got %0d want 0", err_cnt_o); end
  endtask

  task automatic test_loss_of_lock();
    repeat (7) send(1'b1, 1'b0);
    tests++; if (locked_o !== 1'b1) begin fails++; $display("FAIL loss_7_locked: got %0b want 1", locked_o); end
    tests++; if (err_cnt_o !== 32'd7) begin fails++; $display("FAIL loss_7_err_cnt: got %0d want 7", err_cnt_o); end
    send(1'b1, 1'b0);
    tests++; if (locked_o !== 1'b0) begin fails++; $display("FAIL loss_8_locked: got %0b want 0", locked_o); end
    tests++; if (err_cnt_o !== 32'd8) begin fails++; $display("FAIL loss_8_err_cnt: got %0d want 8", err_cnt_o); end
    tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL loss_8_err: got %0b want 1", err_o); end
    send_n(23);
    tests++; if (locked_o !== 1'b0) begin fails++; $display("FAIL loss_relock_early: got %0b want 0", locked_o); end
    send(1'b0, 1'b0);
    tests++; if (locked_o !== 1'b1) begin fails++; $display("FAIL loss_relock_24: got %0b want 1", locked_o); end
    tests++; if (err_cnt_o !== 32'd8) begin fails++; $display("FAIL loss_relock_err_cnt: got %0d want 8", err_cnt_o); end
  endtask

  task automatic test_dead_line();
    int lock_seen;
    #2;
    reset_ni = 1'b0;
    #2;
    reset_ni = 1'b1;
    @(posedge clk_i);
    #1;
    lock_seen = 0;
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (locked_o !== 1'b0) lock_seen++;
    end
    tests++; if (lock_seen != 0) begin fails++; $display("FAIL dead_locked_cycles: got %0d want 0", lock_seen); end
    tests++; if (err_cnt_o !== 32'd0) begin fails++; $display("FAIL dead_err_cnt: got %0d want 0", err_cnt_o); end
    tests++; if (bit_cnt_o !== 32'd0) begin fails++; $display("FAIL dead_bit_cnt: got %0d want 0", bit_cnt_o); end
  endtask

  initial begin
    @(posedge clk_i);
    #1;
    test_reset();
    test_clean_lock();
    test_single_error();
    test_gaps_clear();
    test_async_reset();
    test_loss_of_lock();
    test_dead_line();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
